// File: rtl/z80fi_insn_collector_pkg.sv
// z80fi_insn_collector_pkg
//   Shared definitions for the z80fi instruction collector:
//   - M-cycle type codes carried in the z80fi packet
//   - packet geometry (M-cycle slots, instruction byte slots)
//   - collector FSM state type and bus-transfer record
package z80fi_insn_collector_pkg;

    localparam int MAX_MCYCLES    = 4;
    localparam int MAX_INSN_BYTES = 4;

    localparam logic [2:0] CYCLE_NONE     = 3'd0;
    localparam logic [2:0] CYCLE_M1       = 3'd1;
    localparam logic [2:0] CYCLE_RDWR_MEM = 3'd2;
    localparam logic [2:0] CYCLE_RDWR_IO  = 3'd3;
    localparam logic [2:0] CYCLE_INTERNAL = 3'd4;
    localparam logic [2:0] CYCLE_INTACK   = 3'd5;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_xfer_t;

    // Transfer counter that sticks at 2: only two capture slots exist.
    function automatic logic [1:0] sat_inc2(input logic [1:0] cnt);
        return (cnt == 2'd2) ? cnt : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/z80fi_insn_collector_mcycle_slots.sv
// z80fi_insn_collector_mcycle_slots
//   Per-instruction M-cycle slot record: slot index, type/T-cycle arrays and
//   the slot-overflow bit.
//   Ports:
//     clk, reset_n        clock, async active-low reset
//     clear               start a fresh record on the next clock
//     record              an M-cycle belonging to the current record completed
//     mc_type, mc_tcycles type code / T-cycle count of that M-cycle
//     view_type/_tcycles  record contents including this clock's M-cycle
//     view_ovf            slot overflow including this clock's M-cycle
//   The view outputs are combinational so the packet can be built in the same
//   clock that the final M-cycle completes.
module z80fi_insn_collector_mcycle_slots
    import z80fi_insn_collector_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         record,
    input  logic [2:0]                   mc_type,
    input  logic [2:0]                   mc_tcycles,
    output logic [MAX_MCYCLES-1:0][2:0]  view_type,
    output logic [MAX_MCYCLES-1:0][2:0]  view_tcycles,
    output logic                         view_ovf
);

    logic [2:0]                  idx, idx_nxt;
    logic [MAX_MCYCLES-1:0][2:0] slot_type;
    logic [MAX_MCYCLES-1:0][2:0] slot_tcycles;
    logic                        ovf;

    always_comb begin
        view_type    = slot_type;
        view_tcycles = slot_tcycles;
        view_ovf     = ovf;
        idx_nxt      = idx;
        if (record) begin
            if (idx < 3'(MAX_MCYCLES)) begin
                view_type[idx[1:0]]    = mc_type;
                view_tcycles[idx[1:0]] = mc_tcycles;
                idx_nxt                = idx + 3'd1;
            end else begin
                view_ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx          <= '0;
            slot_type    <= {MAX_MCYCLES{CYCLE_NONE}};
            slot_tcycles <= '0;
            ovf          <= 1'b0;
        end else if (clear) begin
            idx          <= '0;
            slot_type    <= {MAX_MCYCLES{CYCLE_NONE}};
            slot_tcycles <= '0;
            ovf          <= 1'b0;
        end else begin
            idx          <= idx_nxt;
            slot_type    <= view_type;
            slot_tcycles <= view_tcycles;
            ovf          <= view_ovf;
        end
    end

endmodule

// File: rtl/z80fi_insn_collector.sv
// z80fi_insn_collector
//   Folds the core's per-M-cycle trace strobes into one z80fi packet per
//   retired instruction and strobes z80fi_valid for one clock.
//   Inputs:  insn_start + ip/sp/f_in snapshot, mc_done + M-cycle description
//            (type, tcycles, addr, data, write, insn_byte), insn_done +
//            ip/sp/f_out snapshot.
//   Outputs: z80fi_valid, instruction bytes/length, register in/out,
//            two read and two write captures, four M-cycle type/T-cycle
//            slots, overflow flag.
//   Build option: define Z80FI_ORDER_EN to add the 64-bit z80fi_order output
//   (number of packets emitted before the one on display).
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no instruction in flight; mc_done/insn_done ignored
//   ST_COLLECT | accumulating M-cycles of the current instruction
module z80fi_insn_collector
    import z80fi_insn_collector_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        insn_start,
    input  logic [15:0] ip_in,
    input  logic [15:0] sp_in,
    input  logic [7:0]  f_in,
    input  logic        mc_done,
    input  logic [2:0]  mc_type,
    input  logic [2:0]  mc_tcycles,
    input  logic [15:0] mc_addr,
    input  logic [7:0]  mc_data,
    input  logic        mc_write,
    input  logic        mc_insn_byte,
    input  logic        insn_done,
    input  logic [15:0] ip_out,
    input  logic [15:0] sp_out,
    input  logic [7:0]  f_out,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [15:0] z80fi_reg_ip_in,
    output logic [15:0] z80fi_reg_ip_out,
    output logic [15:0] z80fi_reg_sp_in,
    output logic [15:0] z80fi_reg_sp_out,
    output logic [7:0]  z80fi_reg_f_in,
    output logic [7:0]  z80fi_reg_f_out,
    output logic [15:0] z80fi_bus_raddr,
    output logic [15:0] z80fi_bus_raddr2,
    output logic [15:0] z80fi_bus_waddr,
    output logic [15:0] z80fi_bus_waddr2,
    output logic [7:0]  z80fi_bus_rdata,
    output logic [7:0]  z80fi_bus_rdata2,
    output logic [7:0]  z80fi_bus_wdata,
    output logic [7:0]  z80fi_bus_wdata2,
    output logic [2:0]  z80fi_mcycle_type1,
    output logic [2:0]  z80fi_mcycle_type2,
    output logic [2:0]  z80fi_mcycle_type3,
    output logic [2:0]  z80fi_mcycle_type4,
    output logic [2:0]  z80fi_tcycles1,
    output logic [2:0]  z80fi_tcycles2,
    output logic [2:0]  z80fi_tcycles3,
    output logic [2:0]  z80fi_tcycles4,
`ifdef Z80FI_ORDER_EN
    output logic [63:0] z80fi_order,
`endif
    output logic        z80fi_overflow
);

    state_t state, state_nxt;
    logic   emit, clear, record;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // An insn_start without insn_done abandons the open record, so an M-cycle
    // completing in that clock belongs to nothing. With insn_done it closes
    // the old packet and is kept.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        clear     = insn_start;
        record    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (insn_start) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                emit   = insn_done;
                record = mc_done && (insn_done || !insn_start);
                if (insn_start)     state_nxt = ST_COLLECT;
                else if (insn_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    logic [MAX_MCYCLES-1:0][2:0] view_type, view_tcycles;
    logic                        slot_ovf;

    z80fi_insn_collector_mcycle_slots u_slots (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .record       (record),
        .mc_type      (mc_type),
        .mc_tcycles   (mc_tcycles),
        .view_type    (view_type),
        .view_tcycles (view_tcycles),
        .view_ovf     (slot_ovf)
    );

    logic [31:0] insn_r, insn_v;
    logic [2:0]  len_r, len_v;
    logic [1:0]  rcnt_r, rcnt_v, wcnt_r, wcnt_v;
    bus_xfer_t   rd0_r, rd0_v, rd1_r, rd1_v, wr0_r, wr0_v, wr1_r, wr1_v;
    logic        ovf_r, ovf_v;
    logic [15:0] ip_in_r, sp_in_r;
    logic [7:0]  f_in_r;
    bus_xfer_t   xfer;

    assign xfer = {mc_addr, mc_data};

    always_comb begin
        insn_v = insn_r;
        len_v  = len_r;
        rcnt_v = rcnt_r;
        wcnt_v = wcnt_r;
        rd0_v  = rd0_r;
        rd1_v  = rd1_r;
        wr0_v  = wr0_r;
        wr1_v  = wr1_r;
        ovf_v  = ovf_r;
        if (record) begin
            if (mc_insn_byte) begin
                if (len_r < 3'(MAX_INSN_BYTES)) begin
                    insn_v[{len_r[1:0], 3'b000} +: 8] = mc_data;
                    len_v = len_r + 3'd1;
                end else begin
                    ovf_v = 1'b1;
                end
            end else if (mc_type == CYCLE_RDWR_MEM) begin
                if (mc_write) begin
                    case (wcnt_r)
                        2'd0:    wr0_v = xfer;
                        2'd1:    wr1_v = xfer;
                        default: ovf_v = 1'b1;
                    endcase
                    wcnt_v = sat_inc2(wcnt_r);
                end else begin
                    case (rcnt_r)
                        2'd0:    rd0_v = xfer;
                        2'd1:    rd1_v = xfer;
                        default: ovf_v = 1'b1;
                    endcase
                    rcnt_v = sat_inc2(rcnt_r);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            insn_r  <= '0;
            len_r   <= '0;
            rcnt_r  <= '0;
            wcnt_r  <= '0;
            rd0_r   <= '0;
            rd1_r   <= '0;
            wr0_r   <= '0;
            wr1_r   <= '0;
            ovf_r   <= 1'b0;
            ip_in_r <= '0;
            sp_in_r <= '0;
            f_in_r  <= '0;
        end else if (clear) begin
            insn_r  <= '0;
            len_r   <= '0;
            rcnt_r  <= '0;
            wcnt_r  <= '0;
            rd0_r   <= '0;
            rd1_r   <= '0;
            wr0_r   <= '0;
            wr1_r   <= '0;
            ovf_r   <= 1'b0;
            ip_in_r <= ip_in;
            sp_in_r <= sp_in;
            f_in_r  <= f_in;
        end else begin
            insn_r  <= insn_v;
            len_r   <= len_v;
            rcnt_r  <= rcnt_v;
            wcnt_r  <= wcnt_v;
            rd0_r   <= rd0_v;
            rd1_r   <= rd1_v;
            wr0_r   <= wr0_v;
            wr1_r   <= wr1_v;
            ovf_r   <= ovf_v;
        end
    end

    // Packet registers load from the *_v views so an M-cycle finishing in the
    // insn_done clock is part of the packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z80fi_valid        <= 1'b0;
            z80fi_insn         <= '0;
            z80fi_insn_len     <= '0;
            z80fi_reg_ip_in    <= '0;
            z80fi_reg_ip_out   <= '0;
            z80fi_reg_sp_in    <= '0;
            z80fi_reg_sp_out   <= '0;
            z80fi_reg_f_in     <= '0;
            z80fi_reg_f_out    <= '0;
            z80fi_bus_raddr    <= '0;
            z80fi_bus_rdata    <= '0;
            z80fi_bus_raddr2   <= '0;
            z80fi_bus_rdata2   <= '0;
            z80fi_bus_waddr    <= '0;
            z80fi_bus_wdata    <= '0;
            z80fi_bus_waddr2   <= '0;
            z80fi_bus_wdata2   <= '0;
            z80fi_mcycle_type1 <= CYCLE_NONE;
            z80fi_mcycle_type2 <= CYCLE_NONE;
            z80fi_mcycle_type3 <= CYCLE_NONE;
            z80fi_mcycle_type4 <= CYCLE_NONE;
            z80fi_tcycles1     <= '0;
            z80fi_tcycles2     <= '0;
            z80fi_tcycles3     <= '0;
            z80fi_tcycles4     <= '0;
            z80fi_overflow     <= 1'b0;
        end else begin
            z80fi_valid <= emit;
            if (emit) begin
                z80fi_insn         <= insn_v;
                z80fi_insn_len     <= len_v;
                z80fi_reg_ip_in    <= ip_in_r;
                z80fi_reg_ip_out   <= ip_out;
                z80fi_reg_sp_in    <= sp_in_r;
                z80fi_reg_sp_out   <= sp_out;
                z80fi_reg_f_in     <= f_in_r;
                z80fi_reg_f_out    <= f_out;
                z80fi_bus_raddr    <= rd0_v.addr;
                z80fi_bus_rdata    <= rd0_v.data;
                z80fi_bus_raddr2   <= rd1_v.addr;
                z80fi_bus_rdata2   <= rd1_v.data;
                z80fi_bus_waddr    <= wr0_v.addr;
                z80fi_bus_wdata    <= wr0_v.data;
                z80fi_bus_waddr2   <= wr1_v.addr;
                z80fi_bus_wdata2   <= wr1_v.data;
                z80fi_mcycle_type1 <= view_type[0];
                z80fi_mcycle_type2 <= view_type[1];
                z80fi_mcycle_type3 <= view_type[2];
                z80fi_mcycle_type4 <= view_type[3];
                z80fi_tcycles1     <= view_tcycles[0];
                z80fi_tcycles2     <= view_tcycles[1];
                z80fi_tcycles3     <= view_tcycles[2];
                z80fi_tcycles4     <= view_tcycles[3];
                z80fi_overflow     <= slot_ovf | ovf_v;
            end
        end
    end

`ifdef Z80FI_ORDER_EN
    logic [63:0] order_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            order_cnt   <= '0;
            z80fi_order <= '0;
        end else if (emit) begin
            z80fi_order <= order_cnt;
            order_cnt   <= order_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// tb_z80fi_insn_collector
//   Directed and random instructions played into the collector; each packet
//   is compared against a list-based reference built from the M-cycles sent.
module tb_z80fi_insn_collector;
    import z80fi_insn_collector_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        insn_start, mc_done, mc_write, mc_insn_byte, insn_done;
    logic [15:0] ip_in, sp_in, ip_out, sp_out, mc_addr;
    logic [7:0]  f_in, f_out, mc_data;
    logic [2:0]  mc_type, mc_tcycles;
    logic        z80fi_valid, z80fi_overflow;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_sp_in, z80fi_reg_sp_out;
    logic [7:0]  z80fi_reg_f_in, z80fi_reg_f_out;
    logic [15:0] z80fi_bus_raddr, z80fi_bus_raddr2, z80fi_bus_waddr, z80fi_bus_waddr2;
    logic [7:0]  z80fi_bus_rdata, z80fi_bus_rdata2, z80fi_bus_wdata, z80fi_bus_wdata2;
    logic [2:0]  z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4;
    logic [2:0]  z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4;
`ifdef Z80FI_ORDER_EN
    logic [63:0] z80fi_order;
`endif

    always #5 clk = ~clk;

    z80fi_insn_collector dut (
        .clk(clk), .reset_n(reset_n), .insn_start(insn_start),
        .ip_in(ip_in), .sp_in(sp_in), .f_in(f_in),
        .mc_done(mc_done), .mc_type(mc_type), .mc_tcycles(mc_tcycles),
        .mc_addr(mc_addr), .mc_data(mc_data), .mc_write(mc_write),
        .mc_insn_byte(mc_insn_byte), .insn_done(insn_done),
        .ip_out(ip_out), .sp_out(sp_out), .f_out(f_out),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_ip_out(z80fi_reg_ip_out),
        .z80fi_reg_sp_in(z80fi_reg_sp_in), .z80fi_reg_sp_out(z80fi_reg_sp_out),
        .z80fi_reg_f_in(z80fi_reg_f_in), .z80fi_reg_f_out(z80fi_reg_f_out),
        .z80fi_bus_raddr(z80fi_bus_raddr), .z80fi_bus_raddr2(z80fi_bus_raddr2),
        .z80fi_bus_waddr(z80fi_bus_waddr), .z80fi_bus_waddr2(z80fi_bus_waddr2),
        .z80fi_bus_rdata(z80fi_bus_rdata), .z80fi_bus_rdata2(z80fi_bus_rdata2),
        .z80fi_bus_wdata(z80fi_bus_wdata), .z80fi_bus_wdata2(z80fi_bus_wdata2),
        .z80fi_mcycle_type1(z80fi_mcycle_type1), .z80fi_mcycle_type2(z80fi_mcycle_type2),
        .z80fi_mcycle_type3(z80fi_mcycle_type3), .z80fi_mcycle_type4(z80fi_mcycle_type4),
        .z80fi_tcycles1(z80fi_tcycles1), .z80fi_tcycles2(z80fi_tcycles2),
        .z80fi_tcycles3(z80fi_tcycles3), .z80fi_tcycles4(z80fi_tcycles4),
`ifdef Z80FI_ORDER_EN
        .z80fi_order(z80fi_order),
`endif
        .z80fi_overflow(z80fi_overflow)
    );

    typedef struct packed {
        logic [2:0]  typ;
        logic [2:0]  tc;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic        ib;
    } mc_t;

    mc_t         mcs[$];
    logic [15:0] ip_i, sp_i, ip_o, sp_o;
    logic [7:0]  f_i, f_o;

    // expected packet
    logic [31:0] e_insn;
    logic [2:0]  e_len;
    logic [15:0] e_ra, e_ra2, e_wa, e_wa2;
    logic [7:0]  e_rd, e_rd2, e_wd, e_wd2;
    logic [2:0]  e_type[4];
    logic [2:0]  e_tc[4];
    logic        e_ovf;
    longint      n_pkts = 0;

    int  n_assert = 0;
    int  n_fail   = 0;
    time t_valid  = 0;
    time t_first  = 0;

    function automatic mc_t mk(input logic [2:0] typ, input logic [2:0] tc, input logic [15:0] addr,
                               input logic [7:0] data, input logic wr, input logic ib);
        mc_t m;
        m.typ = typ; m.tc = tc; m.addr = addr; m.data = data; m.wr = wr; m.ib = ib;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        insn_start = 0; mc_done = 0; insn_done = 0; mc_write = 0; mc_insn_byte = 0;
        mc_type = 0; mc_tcycles = 0; mc_addr = 0; mc_data = 0;
        ip_in = 0; sp_in = 0; f_in = 0; ip_out = 0; sp_out = 0; f_out = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        clear_inputs();
        insn_start = 1; ip_in = ip_i; sp_in = sp_i; f_in = f_i;
        @(posedge clk);
    endtask

    // Plays mcs; with fin the last M-cycle carries insn_done, with chain it
    // also carries insn_start for the next instruction.
    task automatic play(input bit fin, input bit chain, input logic [15:0] nip,
                        input logic [15:0] nsp, input logic [7:0] nf);
        foreach (mcs[i]) begin
            @(negedge clk);
            clear_inputs();
            mc_done = 1; mc_type = mcs[i].typ; mc_tcycles = mcs[i].tc; mc_addr = mcs[i].addr;
            mc_data = mcs[i].data; mc_write = mcs[i].wr; mc_insn_byte = mcs[i].ib;
            if (fin && i == mcs.size() - 1) begin
                insn_done = 1; ip_out = ip_o; sp_out = sp_o; f_out = f_o;
                if (chain) begin
                    insn_start = 1; ip_in = nip; sp_in = nsp; f_in = nf;
                end
            end
            @(posedge clk);
        end
    endtask

    // Reference: first four M-cycles fill the slots, bytes fill the opcode
    // word in order, non-opcode memory transfers fill two read and two write
    // captures; anything beyond any of those limits flags overflow.
    task automatic model();
        int len, nr, nw;
        len = 0; nr = 0; nw = 0;
        e_insn = 0; e_ovf = 0;
        e_ra = 0; e_rd = 0; e_ra2 = 0; e_rd2 = 0;
        e_wa = 0; e_wd = 0; e_wa2 = 0; e_wd2 = 0;
        for (int k = 0; k < 4; k++) begin e_type[k] = CYCLE_NONE; e_tc[k] = 0; end
        foreach (mcs[i]) begin
            if (i < 4) begin e_type[i] = mcs[i].typ; e_tc[i] = mcs[i].tc; end
            else e_ovf = 1;
            if (mcs[i].ib) begin
                if (len < 4) begin e_insn[8*len +: 8] = mcs[i].data; len++; end
                else e_ovf = 1;
            end else if (mcs[i].typ == CYCLE_RDWR_MEM) begin
                if (mcs[i].wr) begin
                    if (nw == 0) begin e_wa = mcs[i].addr; e_wd = mcs[i].data; end
                    else if (nw == 1) begin e_wa2 = mcs[i].addr; e_wd2 = mcs[i].data; end
                    else e_ovf = 1;
                    nw++;
                end else begin
                    if (nr == 0) begin e_ra = mcs[i].addr; e_rd = mcs[i].data; end
                    else if (nr == 1) begin e_ra2 = mcs[i].addr; e_rd2 = mcs[i].data; end
                    else e_ovf = 1;
                    nr++;
                end
            end
        end
        e_len = 3'(len);
    endtask

    task automatic check_pkt(input string tag, input bit check_low);
        @(negedge clk);
        clear_inputs();
        t_valid = $time;
        chk({tag, ".valid"}, z80fi_valid, 1);
        chk({tag, ".insn"}, z80fi_insn, e_insn);
        chk({tag, ".len"}, z80fi_insn_len, e_len);
        chk({tag, ".regs_in"}, {z80fi_reg_ip_in, z80fi_reg_sp_in, z80fi_reg_f_in}, {ip_i, sp_i, f_i});
        chk({tag, ".regs_out"}, {z80fi_reg_ip_out, z80fi_reg_sp_out, z80fi_reg_f_out}, {ip_o, sp_o, f_o});
        chk({tag, ".rd"}, {z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_raddr2, z80fi_bus_rdata2},
            {e_ra, e_rd, e_ra2, e_rd2});
        chk({tag, ".wr"}, {z80fi_bus_waddr, z80fi_bus_wdata, z80fi_bus_waddr2, z80fi_bus_wdata2},
            {e_wa, e_wd, e_wa2, e_wd2});
        chk({tag, ".types"}, {z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4},
            {e_type[0], e_type[1], e_type[2], e_type[3]});
        chk({tag, ".tcycles"}, {z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4},
            {e_tc[0], e_tc[1], e_tc[2], e_tc[3]});
        chk({tag, ".ovf"}, z80fi_overflow, e_ovf);
`ifdef Z80FI_ORDER_EN
        chk({tag, ".order"}, z80fi_order, n_pkts);
`endif
        n_pkts++;
        if (check_low) begin
            @(negedge clk);
            chk({tag, ".valid_drop"}, z80fi_valid, 0);
        end
    endtask

    task automatic set_regs(input logic [15:0] a, input logic [15:0] b, input logic [7:0] c,
                            input logic [15:0] d, input logic [15:0] e, input logic [7:0] f);
        ip_i = a; sp_i = b; f_i = c; ip_o = d; sp_o = e; f_o = f;
    endtask

    task automatic run_insn(input string tag);
        do_start();
        play(1, 0, 0, 0, 0);
        model();
        check_pkt(tag, 1);
    endtask

    initial begin
        int n, kind;
        clear_inputs();
        reset_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.valid", z80fi_valid, 0);
        chk("reset.insn", {z80fi_insn, z80fi_insn_len, z80fi_overflow}, 0);
        chk("reset.types", {z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4},
            {4{CYCLE_NONE}});
        chk("reset.regs", {z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_sp_in, z80fi_reg_sp_out}, 0);
        reset_n = 1;

        // RET Z taken
        set_regs(16'h0100, 16'h1000, 8'h40, 16'h1234, 16'h1002, 8'h40);
        mcs = '{mk(CYCLE_M1, 5, 16'h0100, 8'hC8, 0, 1),
                mk(CYCLE_RDWR_MEM, 3, 16'h1000, 8'h34, 0, 0),
                mk(CYCLE_RDWR_MEM, 3, 16'h1001, 8'h12, 0, 0)};
        run_insn("retz");
        chk("retz.const", {z80fi_insn_len, z80fi_insn[7:0], z80fi_bus_raddr, z80fi_bus_rdata, z80fi_reg_ip_out},
            {3'd1, 8'hC8, 16'h1000, 8'h34, 16'h1234});

        // RET NZ not taken
        set_regs(16'h0100, 16'h2000, 8'h40, 16'h0101, 16'h2000, 8'h40);
        mcs = '{mk(CYCLE_M1, 5, 16'h0100, 8'hC0, 0, 1)};
        run_insn("retnz");
        chk("retnz.const", {z80fi_mcycle_type2, z80fi_tcycles1, z80fi_bus_raddr}, {CYCLE_NONE, 3'd5, 16'h0});

        // mc_done / insn_done while idle are ignored
        @(negedge clk);
        mc_done = 1; insn_done = 1; mc_type = CYCLE_M1; mc_tcycles = 4; mc_data = 8'hFF; mc_insn_byte = 1;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        chk("idle.valid", z80fi_valid, 0);
        chk("idle.hold", {z80fi_insn, z80fi_reg_ip_out}, {e_insn, ip_o});

        // back-to-back: PUSH BC (with writes) then NOP
        set_regs(16'h0200, 16'h3000, 8'h00, 16'h0201, 16'h2FFE, 8'h00);
        mcs = '{mk(CYCLE_M1, 5, 16'h0200, 8'hC5, 0, 1),
                mk(CYCLE_RDWR_MEM, 3, 16'h2FFF, 8'hAB, 1, 0),
                mk(CYCLE_RDWR_MEM, 3, 16'h2FFE, 8'hCD, 1, 0)};
        do_start();
        play(1, 1, 16'h0201, 16'h2FFE, 8'h00);
        model();
        check_pkt("b2b_a", 0);
        t_first = t_valid;
        set_regs(16'h0201, 16'h2FFE, 8'h00, 16'h0202, 16'h2FFE, 8'h00);
        mcs = '{mk(CYCLE_M1, 4, 16'h0201, 8'h00, 0, 1)};
        play(1, 0, 0, 0, 0);
        model();
        check_pkt("b2b_b", 1);
        chk("b2b.spacing", 64'(t_valid - t_first), 64'd20);

        // five M-cycles, five bytes
        set_regs(16'h0300, 16'h4000, 8'h01, 16'h0305, 16'h4000, 8'h01);
        mcs = '{mk(CYCLE_M1, 4, 16'h0300, 8'hDD, 0, 1), mk(CYCLE_M1, 4, 16'h0301, 8'hCB, 0, 1),
                mk(CYCLE_RDWR_MEM, 3, 16'h0302, 8'h05, 0, 1), mk(CYCLE_RDWR_MEM, 5, 16'h0303, 8'h06, 0, 1),
                mk(CYCLE_RDWR_MEM, 3, 16'h0304, 8'h77, 0, 1)};
        run_insn("ovf5");
        chk("ovf5.const", {z80fi_overflow, z80fi_insn_len, z80fi_insn}, {1'b1, 3'd4, 32'h0605CBDD});

        // three reads
        set_regs(16'h0400, 16'h5000, 8'h00, 16'h0401, 16'h5000, 8'h00);
        mcs = '{mk(CYCLE_M1, 4, 16'h0400, 8'hED, 0, 1), mk(CYCLE_RDWR_MEM, 3, 16'h6000, 8'h11, 0, 0),
                mk(CYCLE_RDWR_MEM, 3, 16'h6001, 8'h22, 0, 0), mk(CYCLE_RDWR_MEM, 3, 16'h6002, 8'h33, 0, 0)};
        run_insn("ovf_rd");
        chk("ovf_rd.const", {z80fi_overflow, z80fi_bus_raddr2}, {1'b1, 16'h6001});

        // insn_start mid-collect discards the old record
        set_regs(16'h0500, 16'h1111, 8'hFF, 16'h0, 16'h0, 8'h0);
        mcs = '{mk(CYCLE_M1, 4, 16'h0500, 8'h3E, 0, 1), mk(CYCLE_RDWR_MEM, 3, 16'h7000, 8'h99, 0, 0)};
        do_start();
        play(0, 0, 0, 0, 0);
        set_regs(16'h0600, 16'h2222, 8'h80, 16'h0601, 16'h2222, 8'h80);
        mcs = '{mk(CYCLE_M1, 6, 16'h0600, 8'h3C, 0, 1)};
        run_insn("restart");

        // reset mid-collect
        set_regs(16'h0700, 16'h3333, 8'h11, 16'h0, 16'h0, 8'h0);
        mcs = '{mk(CYCLE_M1, 4, 16'h0700, 8'h21, 0, 1), mk(CYCLE_RDWR_MEM, 3, 16'h0701, 8'h34, 0, 1)};
        do_start();
        play(0, 0, 0, 0, 0);
        @(negedge clk);
        clear_inputs();
        reset_n = 0;
        #1;
        chk("rst_mid.valid", z80fi_valid, 0);
        chk("rst_mid.pkt", {z80fi_insn, z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_tcycles1, z80fi_mcycle_type1}, 0);
`ifdef Z80FI_ORDER_EN
        chk("rst_mid.order", z80fi_order, 0);
`endif
        n_pkts = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("rst_mid.no_valid", z80fi_valid, 0);
        set_regs(16'h0800, 16'h4444, 8'h22, 16'h0803, 16'h4444, 8'h22);
        mcs = '{mk(CYCLE_M1, 4, 16'h0800, 8'h21, 0, 1), mk(CYCLE_RDWR_MEM, 3, 16'h0801, 8'h34, 0, 1),
                mk(CYCLE_RDWR_MEM, 3, 16'h0802, 8'h12, 0, 1)};
        run_insn("post_rst");

        // random instructions
        for (int r = 0; r < 30; r++) begin
            set_regs(16'($urandom), 16'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
            mcs.delete();
            mcs.push_back(mk(CYCLE_M1, 3'($urandom_range(4, 6)), ip_i, 8'($urandom), 0, 1));
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) begin
                kind = $urandom_range(0, 4);
                case (kind)
                    0: mcs.push_back(mk(CYCLE_RDWR_MEM, 3, 16'($urandom), 8'($urandom), 0, 0));
                    1: mcs.push_back(mk(CYCLE_RDWR_MEM, 3, 16'($urandom), 8'($urandom), 1, 0));
                    2: mcs.push_back(mk(CYCLE_RDWR_MEM, 3, 16'($urandom), 8'($urandom), 0, 1));
                    3: mcs.push_back(mk(CYCLE_RDWR_IO, 4, 16'($urandom), 8'($urandom), 1'($urandom), 0));
                    default: mcs.push_back(mk(CYCLE_INTERNAL, 3'($urandom_range(1, 5)), 16'h0, 8'h0, 0, 0));
                endcase
            end
            run_insn("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
